control_sequencer: RTL and testbench
====================================

# control_sequencer

Moore-style control unit that runs one instruction cycle at a time on the shared 32-bit bus datapath. It fetches through PC/MAR/MDR/IR, decodes IR, and steps three-register ALU, mul/div and nop instructions through timing states. Each state drives exactly one bus source select and the register/ALU strobes. It replaces hand-driven testbench control of the bus encoder/multiplexer and register file.

## Interface
- No parameters; widths fixed by the datapath (32-bit bus, 16 GPRs, 5-bit opcode).
- clock  in  1  system clock, all state changes on rising edge
- clear  in  1  reset, synchronous, active-high
- start  in  1  begin one instruction cycle; sampled only in IDLE
- mem_ready  in  1  memory read data valid on MDR input
- ir  in  32  IR register contents; opcode[31:27], ra[26:23], rb[22:19], rc[18:15]
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE
- err  out  1  high with done when the opcode was illegal
- PCout, MDRout, ZHIout, ZLOout  out  1 each  bus source selects
- Rout  out  16  GPR bus source selects, one-hot
- PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load strobes
- Rin  out  16  GPR load strobes, one-hot
- IncPC, Read  out  1 each  ALU PC-increment request, memory read request
- alu_op  out  5  ALU operation; equals ir[31:27] in T4, else 0

## Operation
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, DONE.
- Opcode classes:
  - ALU: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 shr, 00101 shl, 00110 ror, 00111 rol.
  - MD: 01111 mul, 10000 div.
  - NOP: 11010.
  - Any other opcode is ILLEGAL.
- IDLE: no outputs. Go to T0 if start, else stay.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: ZLOout, PCin, Read. Go to T1W.
- T1W: Read, MDRin = mem_ready. Stay while mem_ready = 0; go to T2 when mem_ready = 1.
- T2: MDRout, IRin. Go to T3.
- T3 (decode; ir is valid here):
  - ALU: Rout[rb], Yin. Go to T4.
  - MD: Rout[ra], Yin. Go to T4.
  - NOP or ILLEGAL: no outputs. Go to DONE.
- T4:
  - ALU: Rout[rc], Zin, alu_op = opcode.
  - MD: Rout[rb], Zin, alu_op = opcode.
  - Go to T5.
- T5:
  - ALU: ZLOout, Rin[ra]. Go to DONE.
  - MD: ZLOout, LOin. Go to T6.
- T6 (MD only): ZHIout, HIin. Go to DONE.
- DONE: done = 1; err = 1 if the opcode was ILLEGAL. Go to IDLE.
- Invariant: at most one bus source select (PCout, MDRout, ZHIout, ZLOout, any Rout bit) is high in any cycle. Rout and Rin are one-hot or zero.
- Opcode class is registered in T3 so that err in DONE does not depend on ir changing after T3.
- start is ignored outside IDLE; it is not queued.
- Rin[0] is permitted; no R0 special-casing.

## Timing
- Every output is a combinational decode of the registered state, plus mem_ready (MDRin, T1W only) and ir (T3/T4/T5 selects).
- Reset: on a clock edge with clear = 1, state becomes IDLE and the class register becomes 0. All outputs are 0 from that cycle on. This holds in every state, including T1W with Read pending.
- clear has priority over start in the same cycle.
- Latency with mem_ready held at 1, counted from the edge that samples start:
  - ALU: T0 is in cycle 1, done in cycle 8.
  - MD: done in cycle 9.
  - NOP/ILLEGAL: done in cycle 6.
  - Each cycle mem_ready is low in T1W adds one cycle.
- The MDR capture edge is the T1W cycle in which mem_ready = 1. The IR capture edge is the end of T2.
- Back-to-back: start high in DONE is ignored. start sampled in the following IDLE cycle gives T0 one cycle later, so there is a 1-cycle minimum gap.

## Test plan
- Reset mid-fetch: start, then hold mem_ready = 0, assert clear in T1W -> next cycle busy = 0, Read = 0, all outputs 0; a later start restarts at T0.
- add R3,R1,R2 (ir = 0x01890000), mem_ready = 1 -> cycle 5 Rout = 0x0002 with Yin; cycle 6 Rout = 0x0004, Zin, alu_op = 0; cycle 7 ZLOout, Rin = 0x0008; cycle 8 done = 1, err = 0.
- mul R4,R5 (ir = 0x7A280000) -> T3 Rout = 0x0010; T4 Rout = 0x0020, alu_op = 01111; T5 ZLOout with LOin; T6 ZHIout with HIin; done in cycle 9.
- Memory wait: mem_ready low for 3 cycles in T1W -> Read high for 4 T1W cycles; MDRin high only in the last one; done delayed by 3 cycles versus the no-wait case.
- nop (ir = 0xD0000000) -> no Rout/Rin/Zin in T3; done in cycle 6, err = 0. Illegal (ir = 0xF8000000) -> done in cycle 6 with err = 1.
- Invariant and start-ignore check: every cycle of all runs above, at most one bus source select high; start pulsed during T2 and DONE -> no extra instruction cycle started.

Source files
------------

// File: rtl/control_sequencer.sv
// Moore control unit for the 32-bit shared-bus datapath.
// Fetches through PC/MAR/MDR/IR, then steps ALU, mul/div and nop instructions.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZHIout,
    output logic        ZLOout,
    output logic [15:0] Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  alu_op
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2,
        S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        C_NOP = 2'd0,
        C_ALU = 2'd1,
        C_MD  = 2'd2,
        C_ILL = 2'd3
    } cls_e;

    state_e state_q, state_d;
    cls_e   cls_q, cls_d, cls_ir;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];

    always_comb begin
        cls_ir = C_ILL;
        unique case (1'b1)
            (opcode[4:3] == 2'b00):                       cls_ir = C_ALU;
            (opcode == 5'b01111) || (opcode == 5'b10000): cls_ir = C_MD;
            (opcode == 5'b11010):                         cls_ir = C_NOP;
            default:                                      cls_ir = C_ILL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T1W;
            S_T1W:  if (mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                // latch the class so err in DONE ignores later ir changes
                cls_d = cls_ir;
                if (cls_ir == C_ALU || cls_ir == C_MD) state_d = S_T4;
                else state_d = S_DONE;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = (cls_q == C_MD) ? S_T6 : S_DONE;
            S_T6:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            cls_q   <= C_NOP;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = 1'b0;
        err    = 1'b0;
        PCout  = 1'b0;
        MDRout = 1'b0;
        ZHIout = 1'b0;
        ZLOout = 1'b0;
        Rout   = 16'd0;
        PCin   = 1'b0;
        MARin  = 1'b0;
        MDRin  = 1'b0;
        IRin   = 1'b0;
        Yin    = 1'b0;
        Zin    = 1'b0;
        HIin   = 1'b0;
        LOin   = 1'b0;
        Rin    = 16'd0;
        IncPC  = 1'b0;
        Read   = 1'b0;
        alu_op = 5'd0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
            end
            S_T1W: begin
                Read  = 1'b1;
                MDRin = mem_ready;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (cls_ir == C_ALU) begin
                    Rout = 16'd1 << rb;
                    Yin  = 1'b1;
                end else if (cls_ir == C_MD) begin
                    Rout = 16'd1 << ra;
                    Yin  = 1'b1;
                end
            end
            S_T4: begin
                Rout   = (cls_q == C_MD) ? (16'd1 << rb) : (16'd1 << rc);
                Zin    = 1'b1;
                alu_op = opcode;
            end
            S_T5: begin
                ZLOout = 1'b1;
                if (cls_q == C_MD) LOin = 1'b1;
                else Rin = 16'd1 << ra;
            end
            S_T6: begin
                ZHIout = 1'b1;
                HIin   = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                err  = (cls_q == C_ILL);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle output traces
// from a vector table plus reset and start/clear corner cases.
module tb_control_sequencer;

    logic        clock, clear, start, mem_ready;
    logic [31:0] ir;
    logic        busy, done, err, PCout, MDRout, ZHIout, ZLOout;
    logic [15:0] Rout, Rin;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic        IncPC, Read;
    logic [4:0]  alu_op;

    control_sequencer dut (
        .clock(clock), .clear(clear), .start(start),
        .mem_ready(mem_ready), .ir(ir),
        .busy(busy), .done(done), .err(err),
        .PCout(PCout), .MDRout(MDRout), .ZHIout(ZHIout), .ZLOout(ZLOout),
        .Rout(Rout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .Rin(Rin), .IncPC(IncPC), .Read(Read), .alu_op(alu_op)
    );

    typedef struct packed {
        logic        busy, done, err, pc_out, mdr_out, zhi_out, zlo_out;
        logic [15:0] rout;
        logic        pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
        logic [15:0] rin;
        logic        inc_pc, read;
        logic [4:0]  alu_op;
    } outs_t;

    localparam int K_ALU = 0;
    localparam int K_MD = 1;
    localparam int K_SHORT = 2;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] ir_late;
        int          wait_n;
        int          kind;
        logic        err;
        logic [15:0] t3;
        logic [15:0] t4;
        logic [15:0] rin;
        logic [4:0]  op;
        int          done_c;
        logic        st_t2;
        logic        st_done;
    } vec_t;

    outs_t act;
    assign act = {busy, done, err, PCout, MDRout, ZHIout, ZLOout, Rout,
                  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, Rin,
                  IncPC, Read, alu_op};

    int total = 0;
    int bad = 0;
    vec_t vecs[10];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(logic [31:0] i, logic [31:0] il, int w,
                                int k, logic e, logic [15:0] r3,
                                logic [15:0] r4, logic [15:0] ri,
                                logic [4:0] o, int dc, logic s2, logic sd);
        vec_t v;
        v.ir = i; v.ir_late = il; v.wait_n = w; v.kind = k; v.err = e;
        v.t3 = r3; v.t4 = r4; v.rin = ri; v.op = o; v.done_c = dc;
        v.st_t2 = s2; v.st_done = sd;
        return v;
    endfunction

    function automatic outs_t exp_out(vec_t v, int c);
        outs_t e;
        int w;
        e = '0;
        w = v.wait_n;
        if (c > v.done_c) return e;
        e.busy = 1'b1;
        if (c == v.done_c) begin
            e.done = 1'b1;
            e.err = v.err;
        end else if (c == 1) begin
            e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.z_in = 1'b1;
        end else if (c == 2) begin
            e.zlo_out = 1'b1; e.pc_in = 1'b1; e.read = 1'b1;
        end else if (c <= 3 + w) begin
            e.read = 1'b1;
            e.mdr_in = (c == 3 + w);
        end else if (c == 4 + w) begin
            e.mdr_out = 1'b1; e.ir_in = 1'b1;
        end else if (c == 5 + w) begin
            if (v.kind != K_SHORT) begin
                e.rout = v.t3; e.y_in = 1'b1;
            end
        end else if (c == 6 + w) begin
            e.rout = v.t4; e.z_in = 1'b1; e.alu_op = v.op;
        end else if (c == 7 + w) begin
            e.zlo_out = 1'b1;
            if (v.kind == K_MD) e.lo_in = 1'b1;
            else e.rin = v.rin;
        end else if (c == 8 + w) begin
            e.zhi_out = 1'b1; e.hi_in = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(string name, int c, outs_t a, outs_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, c, a, e);
        end
    endtask

    task automatic chk_inv(string name, int c);
        int nsrc;
        total++;
        nsrc = int'(PCout) + int'(MDRout) + int'(ZHIout) + int'(ZLOout)
             + $countones(Rout);
        if (nsrc > 1 || $countones(Rin) > 1) begin
            bad++;
            $display("FAIL %s cyc=%0d srcs=%0d rin=%h want <=1 each",
                     name, c, nsrc, Rin);
        end
    endtask

    task automatic run_vec(int idx);
        vec_t v;
        string nm;
        v = vecs[idx];
        nm = $sformatf("vec%0d", idx);
        ir = v.ir;
        start = 1'b1;
        mem_ready = 1'b1;
        @(posedge clock);
        for (int c = 1; c <= v.done_c + 1; c++) begin
            #1;
            start = (v.st_t2 && c == 4 + v.wait_n) ||
                    (v.st_done && c == v.done_c);
            mem_ready = !(c >= 3 && c < 3 + v.wait_n);
            ir = (c >= 6 + v.wait_n) ? v.ir_late : v.ir;
            @(negedge clock);
            chk(nm, c, act, exp_out(v, c));
            chk_inv(nm, c);
            if (c < v.done_c + 1) @(posedge clock);
        end
        start = 1'b0;
    endtask

    initial begin
        // ir, ir_late, wait, kind, err, t3, t4, rin, op, done, stT2, stDONE
        vecs[0] = mk(32'h0189_0000, 32'h0189_0000, 0, K_ALU, 0,
                     16'h0002, 16'h0004, 16'h0008, 5'd0, 8, 0, 0);
        vecs[1] = mk(32'h7A28_0000, 32'h7A28_0000, 0, K_MD, 0,
                     16'h0010, 16'h0020, 16'h0000, 5'd15, 9, 0, 0);
        vecs[2] = mk(32'h0189_0000, 32'h0189_0000, 3, K_ALU, 0,
                     16'h0002, 16'h0004, 16'h0008, 5'd0, 11, 0, 0);
        vecs[3] = mk(32'hD000_0000, 32'hF800_0000, 0, K_SHORT, 0,
                     16'h0000, 16'h0000, 16'h0000, 5'd0, 6, 0, 0);
        vecs[4] = mk(32'hF800_0000, 32'hD000_0000, 0, K_SHORT, 1,
                     16'h0000, 16'h0000, 16'h0000, 5'd0, 6, 0, 0);
        vecs[5] = mk(32'h0F87_0000, 32'h0F87_0000, 1, K_ALU, 0,
                     16'h0001, 16'h4000, 16'h8000, 5'd1, 9, 1, 1);
        vecs[6] = mk(32'h8038_0000, 32'h8038_0000, 0, K_MD, 0,
                     16'h0001, 16'h0080, 16'h0000, 5'd16, 9, 1, 1);
        vecs[7] = mk(32'h3911_0000, 32'h3911_0000, 2, K_ALU, 0,
                     16'h0004, 16'h0004, 16'h0004, 5'd7, 10, 0, 0);
        vecs[8] = mk(32'h4000_0000, 32'h4000_0000, 0, K_SHORT, 1,
                     16'h0000, 16'h0000, 16'h0000, 5'd0, 6, 0, 1);
        vecs[9] = mk(32'hD800_0000, 32'hD800_0000, 0, K_SHORT, 1,
                     16'h0000, 16'h0000, 16'h0000, 5'd0, 6, 0, 0);

        clear = 1'b1;
        start = 1'b0;
        mem_ready = 1'b1;
        ir = 32'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_state", 0, act, '0);
        clear = 1'b0;

        // clear wins over start in IDLE
        clear = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("clear_over_start", 1, act, '0);

        // clear while stalled in T1W with Read pending
        ir = 32'h0189_0000;
        start = 1'b1;
        mem_ready = 1'b0;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            if (c >= 3) begin
                total++;
                if ({busy, Read, MDRin} !== 3'b110) begin
                    bad++;
                    $display("FAIL t1w_wait cyc=%0d got=%b want=110",
                             c, {busy, Read, MDRin});
                end
            end
            if (c < 4) @(posedge clock);
        end
        clear = 1'b1;
        @(posedge clock);
        #1;
        clear = 1'b0;
        mem_ready = 1'b1;
        @(negedge clock);
        chk("clear_in_t1w", 5, act, '0);
        @(negedge clock);
        chk("idle_after_clear", 6, act, '0);

        for (int i = 0; i < 10; i++) run_vec(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
